// File: rtl/dsync_pkg.sv
// Shared types and constants for the data_sync transmit controller.
// Optional ACK_LOW state is only entered when DSYNC_TX_ACK_EN is defined.
package dsync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    GAP     = 2'd2,
    ACK_LOW = 2'd3
  } state_e;

  localparam int MIN_HOLD = 1;
  localparam int MIN_GAP  = 1;

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dsync_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie (or no
// request) goes to the requester opposite the previous winner.
module dsync_rr_arb2 (
  input  logic       req0_valid_i,
  input  logic       req1_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       winner_o
);

  always_comb begin
    winner_o = ~last_grant_i;
    if (req0_valid_i ^ req1_valid_i) begin
      winner_o = req1_valid_i;
    end
    gnt_o = {winner_o, ~winner_o};
  end

endmodule

// File: rtl/data_sync_tx_ctrl.sv
// Source-domain transmit controller for the enable-qualified bus synchronizer.
// Define DSYNC_TX_ACK_EN to replace the fixed HOLD time with a 4-phase dst_ack handshake.
module data_sync_tx_ctrl #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0_valid,
  input  logic [BUS_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [BUS_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  input  logic                 dst_ack,
  output logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic                 bus_enable,
  output logic                 busy
);
  import dsync_pkg::*;

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least %0d", MIN_HOLD);
  end
  if (GAP_CYCLES < MIN_GAP) begin : g_bad_gap
    $error("GAP_CYCLES must be at least %0d", MIN_GAP);
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_dec;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 last_grant_q, last_grant_d;
  logic [1:0]           gnt;
  logic                 winner;
  logic                 accept;

`ifdef DSYNC_TX_ACK_EN
  logic ack;
  assign ack = dst_ack;
`else
  logic unused_dst_ack;
  assign unused_dst_ack = dst_ack;
`endif

  dsync_rr_arb2 u_arb (
    .req0_valid_i (req0_valid),
    .req1_valid_i (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .winner_o     (winner)
  );

  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Enable and busy are registered copies of the next state so they never glitch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
`ifdef DSYNC_TX_ACK_EN
        if (ack) begin
          state_d = ACK_LOW;
        end
`else
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_dec;
        end
`endif
      end
      ACK_LOW: begin
`ifdef DSYNC_TX_ACK_EN
        if (!ack) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
`else
        state_d = IDLE;
`endif
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    req0_ready   = (state_q == IDLE) && gnt[0];
    req1_ready   = (state_q == IDLE) && gnt[1];
    accept       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    data_d       = data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      data_d       = winner ? req1_data : req0_data;
      last_grant_d = winner;
    end
  end

  assign Unsync_bus = data_q;
  assign bus_enable = en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_data_sync_tx_ctrl.sv
// Self-checking bench: two instances (4/4 and 1/1 timing) share one stimulus
// stream and are compared against a time-since-accept reference model.
module tb_data_sync_tx_ctrl;

  localparam int NEVER = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, dst_ack = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic [1:0] en_o, busy_o, rdy0_o, rdy1_o;
  logic [7:0] bus_o [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         t_m   [2];
  logic [7:0] bus_m [2];
  logic       lg_m  [2];
  int         acc_cyc0[$];
  int         acc_cyc1[$];
  logic [7:0] acc_dat0[$];

  always #5 CLK = ~CLK;

  data_sync_tx_ctrl #(.BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)) u_dut0 (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0_o[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1_o[0]),
    .dst_ack(dst_ack), .Unsync_bus(bus_o[0]), .bus_enable(en_o[0]), .busy(busy_o[0])
  );

  data_sync_tx_ctrl #(.BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0_o[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1_o[1]),
    .dst_ack(dst_ack), .Unsync_bus(bus_o[1]), .bus_enable(en_o[1]), .busy(busy_o[1])
  );

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      t_m[k]   = NEVER;
      bus_m[k] = '0;
      lg_m[k]  = 1'b1;
    end
    acc_cyc0.delete();
    acc_cyc1.delete();
    acc_dat0.delete();
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; dst_ack = 1'b0;
    tick();
    tick();
    model_reset();
    RST = 1'b1;
  endtask

  // One clock of stimulus; checks registered outputs, then combinational readys.
  task automatic cycle(input logic v0, input logic v1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic ack);
    logic acc [2];
    logic win [2];
    for (int k = 0; k < 2; k++) begin
      logic e_en, e_busy;
      e_en   = (t_m[k] >= 1) && (t_m[k] <= hold_of(k));
      e_busy = (t_m[k] >= 1) && (t_m[k] <= hold_of(k) + gap_of(k));
      total++;
      if (en_o[k] !== e_en) begin
        bad++;
        $display("FAIL enable dut%0d cyc=%0d got=%b exp=%b", k, cyc, en_o[k], e_en);
      end
      total++;
      if (busy_o[k] !== e_busy) begin
        bad++;
        $display("FAIL busy dut%0d cyc=%0d got=%b exp=%b", k, cyc, busy_o[k], e_busy);
      end
      total++;
      if (bus_o[k] !== bus_m[k]) begin
        bad++;
        $display("FAIL bus dut%0d cyc=%0d got=%h exp=%h", k, cyc, bus_o[k], bus_m[k]);
      end
    end
    req0_valid = v0; req1_valid = v1;
    req0_data  = d0; req1_data  = d1;
    dst_ack    = ack;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic idle, g1, er0, er1;
      idle = !((t_m[k] >= 1) && (t_m[k] <= hold_of(k) + gap_of(k)));
      g1   = (v0 != v1) ? v1 : !lg_m[k];
      er0  = idle && !g1;
      er1  = idle && g1;
      total++;
      if ({rdy1_o[k], rdy0_o[k]} !== {er1, er0}) begin
        bad++;
        $display("FAIL ready dut%0d cyc=%0d got=%b%b exp=%b%b", k, cyc,
                 rdy1_o[k], rdy0_o[k], er1, er0);
      end
      acc[k] = idle && (g1 ? v1 : v0);
      win[k] = g1;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        t_m[k]   = 1;
        bus_m[k] = win[k] ? d1 : d0;
        lg_m[k]  = win[k];
        if (k == 0) begin
          acc_cyc0.push_back(cyc);
          acc_dat0.push_back(bus_m[k]);
        end else begin
          acc_cyc1.push_back(cyc);
        end
      end else if (t_m[k] < NEVER) begin
        t_m[k]++;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; dst_ack = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({en_o[k], busy_o[k], rdy0_o[k], rdy1_o[k], bus_o[k]} !== {4'b0010, 8'h00}) begin
        bad++;
        $display("FAIL reset_state dut%0d got en=%b busy=%b r0=%b r1=%b bus=%h exp 0 0 1 0 00",
                 k, en_o[k], busy_o[k], rdy0_o[k], rdy1_o[k], bus_o[k]);
      end
    end
    model_reset();
    RST = 1'b1;
  endtask

`ifndef DSYNC_TX_ACK_EN
  task automatic test_single;
    int n;
    do_reset();
    n = 0;
    cycle(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (en_o[0] === 1'b1) n++;
      cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL single_en_width got=%0d exp=4", n);
    end
    total++;
    if (bus_o[0] !== 8'hA5) begin
      bad++;
      $display("FAIL single_bus_hold got=%h exp=a5", bus_o[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'($urandom));
    total++;
    if (acc_dat0.size() < 4 || acc_cyc1.size() < 2) begin
      bad++;
      $display("FAIL tie_count got=%0d exp>=4", acc_dat0.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_dat0[i] !== exp_seq[i]) begin
          bad++;
          $display("FAIL tie_seq[%0d] got=%h exp=%h", i, acc_dat0[i], exp_seq[i]);
        end
      end
      total++;
      if (acc_cyc0[1] - acc_cyc0[0] != 9) begin
        bad++;
        $display("FAIL tie_spacing44 got=%0d exp=9", acc_cyc0[1] - acc_cyc0[0]);
      end
      total++;
      if (acc_cyc1[1] - acc_cyc1[0] != 3) begin
        bad++;
        $display("FAIL tie_spacing11 got=%0d exp=3", acc_cyc1[1] - acc_cyc1[0]);
      end
    end
  endtask

  task automatic test_lone_req1;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h33};
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'h44, 8'h33, 1'b0);
    total++;
    if (acc_dat0.size() < 4) begin
      bad++;
      $display("FAIL lone_count got=%0d exp>=4", acc_dat0.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc_dat0[i] !== exp_seq[i]) begin
          bad++;
          $display("FAIL lone_seq[%0d] got=%h exp=%h", i, acc_dat0[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    cycle(1'b1, 1'b0, 8'h5A, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #3;
    RST = 1'b0;
    #1;
    total++;
    if ({en_o[0], busy_o[0], bus_o[0]} !== 10'h000) begin
      bad++;
      $display("FAIL async_reset got en=%b busy=%b bus=%h exp 0 0 00",
               en_o[0], busy_o[0], bus_o[0]);
    end
    tick();
    model_reset();
    RST = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    total++;
    if (acc_dat0.size() < 1 || acc_dat0[0] !== 8'h11) begin
      bad++;
      $display("FAIL post_reset_tie got=%h exp=11",
               (acc_dat0.size() > 0) ? acc_dat0[0] : 8'hxx);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask
`else
  task automatic test_ack;
    int n;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hA5;
    tick();
    req0_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (en_o[0] === 1'b1) n++;
      if (i < 9) tick();
    end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL ack_en_width got=%0d exp=10", n);
    end
    dst_ack = 1'b1;
    tick();
    total++;
    if ({en_o[0], busy_o[0]} !== 2'b01) begin
      bad++;
      $display("FAIL ack_fall got en=%b busy=%b exp 0 1", en_o[0], busy_o[0]);
    end
    tick();
    tick();
    total++;
    if ({en_o[0], busy_o[0], rdy0_o[0]} !== 3'b010) begin
      bad++;
      $display("FAIL ack_low got en=%b busy=%b r0=%b exp 0 1 0", en_o[0], busy_o[0], rdy0_o[0]);
    end
    dst_ack = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy_o[0] !== 1'b1) begin
        bad++;
        $display("FAIL ack_gap[%0d] got busy=%b exp 1", i, busy_o[0]);
      end
      tick();
    end
    total++;
    if ({busy_o[0], bus_o[0]} !== {1'b0, 8'hA5}) begin
      bad++;
      $display("FAIL ack_idle got busy=%b bus=%h exp 0 a5", busy_o[0], bus_o[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DSYNC_TX_ACK_EN
    test_ack();
`else
    test_single();
    test_back_to_back();
    test_lone_req1();
    test_reset_mid_hold();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sync_tx_ctrl.md
# data_sync_tx_ctrl

Source-domain transmit controller for the enable-qualified bus synchronizer. Arbitrates between two requesters with round-robin priority, latches the winning word onto the crossing bus, and drives the enable. It sequences enable high-time and low-gap so that every transfer produces exactly one rising edge and one destination enable pulse. Sits in the source clock domain, directly in front of the destination-side bus synchronizer.

## Interface
- BUS_WIDTH, 8, crossing data width
- HOLD_CYCLES, 4, source cycles bus_enable stays high per transfer; minimum 1
- GAP_CYCLES, 4, source cycles bus_enable stays low after each transfer; minimum 1
- CLK  input  1  source-domain clock; one clock only
- RST  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  BUS_WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle when req0_valid is also high
- req1_valid / req1_data / req1_ready  same as requester 0
- dst_ack  input  1  destination acknowledge, already synchronized into CLK; used only with DSYNC_TX_ACK_EN
- Unsync_bus  output  BUS_WIDTH  registered crossing data
- bus_enable  output  1  registered crossing enable
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, HOLD, GAP, plus ACK_LOW when DSYNC_TX_ACK_EN is defined.
- IDLE:
  - the ready of the granted requester equals 1; the other ready equals 0.
  - Grant is round-robin: if only one valid is high, that requester is granted. If both are high, grant goes to the requester opposite to last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Accept means granted valid && ready in IDLE. On accept, next cycle:
  - Unsync_bus takes the accepted data.
  - bus_enable goes to 1.
  - last_grant records the winner.
  - the counter loads HOLD_CYCLES-1.
  - state goes to HOLD.
- HOLD: bus_enable stays 1 and the counter decrements. When the counter reaches 0:
  - bus_enable goes to 0.
  - the counter loads GAP_CYCLES-1.
  - state goes to GAP.
- GAP: bus_enable stays 0. When the counter reaches 0, state goes to IDLE.
- Both readys are 0 in every state other than IDLE.
- Unsync_bus holds its value from acceptance until the next accept, including through GAP and IDLE. The destination samples it several destination cycles after the enable edge.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). Arithmetic is unsigned and saturates at 0; it never wraps.
- Reset at any time, including mid-HOLD: every register returns to its reset value on the same edge. A transfer in flight is dropped. If the enable was high it falls, and the destination may or may not see that word.

## Timing
- Reset values: Unsync_bus=0, bus_enable=0, req0_ready=1, req1_ready=0, busy=0, state=IDLE, last_grant=1.
- Ready is combinational from state, valids and last_grant. Every other output is registered.
- Accept at edge N gives bus_enable=1 during cycles N+1 .. N+HOLD_CYCLES, then 0 for GAP_CYCLES cycles.
- The next accept is possible in cycle N+HOLD_CYCLES+GAP_CYCLES+1, giving a throughput of 1 word per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- HOLD_CYCLES=1 and GAP_CYCLES=1 are legal. The counter loads 0 and the state exits after one cycle.

## Configuration
- DSYNC_TX_ACK_EN defined:
  - HOLD ignores the counter and remains until dst_ack=1.
  - It then drops bus_enable and enters ACK_LOW.
  - ACK_LOW waits for dst_ack=0, then loads GAP_CYCLES-1 into the counter and enters GAP.
  - The result is a 4-phase handshake with no timing assumption on the destination clock.
  - dst_ack high while in IDLE or GAP is ignored.
- DSYNC_TX_ACK_EN undefined: dst_ack is unconnected internally. Fixed HOLD/GAP counts as above.

## Structure
- Package dsync_pkg holds:
  - the state enum (IDLE, HOLD, GAP, ACK_LOW)
  - a localparam function for the counter width
  - minimum-legal constants MIN_HOLD=1 and MIN_GAP=1
- Elaboration-time check: error if HOLD_CYCLES or GAP_CYCLES is below the minimum.
- One sub-module, dsync_rr_arb2: a 2-way round-robin grant. Inputs are the two valids and last_grant; outputs are a one-hot grant and the winner index. It is purely combinational.

## Test plan
- Reset, then req0_valid=1 with data 8'hA5: ready0=1 in the first cycle. Unsync_bus=A5 and bus_enable=1 for exactly 4 cycles, then 0 for 4 cycles, with busy=1 throughout.
- Both valids held high with data 8'h11 (req0) and 8'h22 (req1): Unsync_bus sequence 11,22,11,22. Accepts are exactly 9 cycles apart.
- req1 alone after a req1 win: req1 is granted again, since there is no starvation of a lone requester. Readys stay 0 during HOLD/GAP even with valid high.
- Reset asserted in cycle 2 of HOLD: bus_enable=0 and Unsync_bus=0 immediately (asynchronously). After release, state is IDLE and the next tie goes to req0.
- HOLD_CYCLES=1 and GAP_CYCLES=1: enable high for 1 cycle, low for 1 cycle, accepts 3 cycles apart.
- With DSYNC_TX_ACK_EN, dst_ack raised 10 cycles after enable: enable stays high for exactly 10 cycles. It falls the cycle after ack is seen, and IDLE is reached GAP_CYCLES cycles after ack falls.
